// File: rtl/seg_scan_driver.sv
// Time-multiplexed scan controller for an N-digit common-anode 7-segment display.
// Drives one digit code plus LT/BI/RBI into a BCD-to-7-segment decoder per scan slot
// and enables that digit's anode, with a dark gap between slots against ghosting.
// Optional feature macro: LEADING_ZERO_BLANK_EN enables leading-zero blanking chained
// through the decoder's RBO output; without it rbi_n is tied high and rbo_in is ignored.
module seg_scan_driver #(
  parameter int unsigned N_DIGITS  = 4,
  parameter int unsigned PRESCALE  = 1000,
  parameter int unsigned BLANK_CYC = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  lamp_tst,
  input  logic [4*N_DIGITS-1:0] bcd_in,
  input  logic                  rbo_in,
  output logic [3:0]            dcba,
  output logic                  lt_n,
  output logic                  bi_n,
  output logic                  rbi_n,
  output logic [N_DIGITS-1:0]   anode_n,
  output logic                  frame
);

  localparam int unsigned CntMax = (PRESCALE > BLANK_CYC) ? PRESCALE : BLANK_CYC;
  localparam int unsigned CntW   = $clog2(CntMax + 1);
  localparam int unsigned IdxW   = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  localparam logic [IdxW-1:0] IdxTop    = IdxW'(N_DIGITS - 1);
  localparam logic [CntW-1:0] BlankLast = CntW'(BLANK_CYC - 1);
  localparam logic [CntW-1:0] ShowLast  = CntW'(PRESCALE - 1);

  typedef enum logic [1:0] {StIdle, StBlank, StShow} state_e;

  state_e                state_q, state_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [4*N_DIGITS-1:0] snapshot_q, snapshot_d;

  logic [3:0]            dcba_q, dcba_d;
  logic                  lt_n_q, lt_n_d;
  logic                  bi_n_q, bi_n_d;
  logic                  rbi_n_q, rbi_n_d;
  logic [N_DIGITS-1:0]   anode_n_q, anode_n_d;
  logic                  frame_q, frame_d;

`ifdef LEADING_ZERO_BLANK_EN
  // 1 while every digit scanned so far in this frame was blanked by the decoder.
  logic zero_chain_q, zero_chain_d;
`else
  logic unused_rbo;
  assign unused_rbo = rbo_in;
`endif

  // Scan sequencing: state, digit index, phase counter and frame snapshot.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    snapshot_d = snapshot_q;
    if (!en) begin
      state_d    = StIdle;
      idx_d      = IdxTop;
      cnt_d      = '0;
      snapshot_d = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          state_d    = StBlank;
          idx_d      = IdxTop;
          cnt_d      = '0;
          snapshot_d = bcd_in;
        end
        StBlank: begin
          if (cnt_q == BlankLast) begin
            state_d = StShow;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        StShow: begin
          if (cnt_q == ShowLast) begin
            state_d = StBlank;
            cnt_d   = '0;
            if (idx_q == '0) begin
              // Wrapping back to the MS digit starts a new frame.
              idx_d      = IdxTop;
              snapshot_d = bcd_in;
            end else begin
              idx_d = idx_q - IdxW'(1);
            end
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        default: begin
          state_d = StIdle;
          idx_d   = IdxTop;
          cnt_d   = '0;
        end
      endcase
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  // Leading-zero chain: RBO is only meaningful on the last SHOW cycle, with BI released.
  always_comb begin
    zero_chain_d = zero_chain_q;
    if (!en || state_q == StIdle) begin
      zero_chain_d = 1'b1;
    end else if (state_q == StShow && cnt_q == ShowLast) begin
      zero_chain_d = (idx_q == '0) ? 1'b1 : (zero_chain_q & ~rbo_in);
    end
  end
`endif

  // Output next-state, decoded from the upcoming scan state so outputs align with it.
  always_comb begin
    dcba_d    = 4'd0;
    lt_n_d    = ~lamp_tst;
    bi_n_d    = 1'b0;
    rbi_n_d   = 1'b1;
    anode_n_d = '1;
    frame_d   = 1'b0;
    if (state_d != StIdle) begin
      for (int unsigned k = 0; k < N_DIGITS; k++) begin
        if (idx_d == IdxW'(k)) begin
          dcba_d = snapshot_d[4*k +: 4];
        end
      end
    end
    if (state_d == StShow) begin
      bi_n_d = 1'b1;
      for (int unsigned k = 0; k < N_DIGITS; k++) begin
        anode_n_d[k] = (idx_d != IdxW'(k));
      end
      frame_d = (state_q == StBlank) && (idx_d == IdxTop);
    end
`ifdef LEADING_ZERO_BLANK_EN
    // Lamp test must light every segment, so it overrides ripple blanking.
    if (state_d != StIdle && !lamp_tst) begin
      if (idx_d == IdxTop) begin
        rbi_n_d = 1'b0;
      end else if (idx_d != '0) begin
        rbi_n_d = ~zero_chain_d;
      end
    end
`endif
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      idx_q        <= IdxTop;
      cnt_q        <= '0;
      snapshot_q   <= '0;
`ifdef LEADING_ZERO_BLANK_EN
      zero_chain_q <= 1'b1;
`endif
      dcba_q       <= 4'd0;
      lt_n_q       <= 1'b1;
      bi_n_q       <= 1'b0;
      rbi_n_q      <= 1'b1;
      anode_n_q    <= '1;
      frame_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      snapshot_q   <= snapshot_d;
`ifdef LEADING_ZERO_BLANK_EN
      zero_chain_q <= zero_chain_d;
`endif
      dcba_q       <= dcba_d;
      lt_n_q       <= lt_n_d;
      bi_n_q       <= bi_n_d;
      rbi_n_q      <= rbi_n_d;
      anode_n_q    <= anode_n_d;
      frame_q      <= frame_d;
    end
  end

  assign dcba    = dcba_q;
  assign lt_n    = lt_n_q;
  assign bi_n    = bi_n_q;
  assign rbi_n   = rbi_n_q;
  assign anode_n = anode_n_q;
  assign frame   = frame_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver: 7447-style decoder model for RBO, a timeline reference
// model checked every cycle, a table of per-digit expectations, and corner sequences.
module tb_seg_scan_driver;

  localparam int N     = 4;
  localparam int P     = 4;
  localparam int B     = 2;
  localparam int SLOT  = B + P;
  localparam int FRAME = N * SLOT;
`ifdef LEADING_ZERO_BLANK_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        lamp_tst;
  logic [15:0] bcd_in;
  logic        rbo_in;
  logic [3:0]  dcba;
  logic        lt_n;
  logic        bi_n;
  logic        rbi_n;
  logic [3:0]  anode_n;
  logic        frame;

  seg_scan_driver #(
    .N_DIGITS (N),
    .PRESCALE (P),
    .BLANK_CYC(B)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .lamp_tst(lamp_tst),
    .bcd_in  (bcd_in),
    .rbo_in  (rbo_in),
    .dcba    (dcba),
    .lt_n    (lt_n),
    .bi_n    (bi_n),
    .rbi_n   (rbi_n),
    .anode_n (anode_n),
    .frame   (frame)
  );

  // 7447 decoder: RBO low only when it blanks a zero under RBI; BI low pulls the pin low.
  assign rbo_in = bi_n & ~(lt_n & ~rbi_n & (dcba == 4'd0));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors    = 0;
  int miscompares = 0;
  bit chk_on     = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference model: position on the scan timeline since the controller left idle.
  int          run_t  = -1;
  logic [15:0] snap   = '0;
  bit          lt_exp = 1'b1;
  bit          dirty  = 1'b0;  // lamp test touched this frame's blanking chain

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_t  = -1;
      snap   = '0;
      lt_exp = 1'b1;
      dirty  = 1'b0;
    end else begin
      lt_exp = !lamp_tst;
      if (!en) begin
        run_t = -1;
        snap  = '0;
        dirty = 1'b0;
      end else begin
        run_t++;
        if (run_t % FRAME == 0) begin
          snap  = bcd_in;
          dirty = 1'b0;
        end else if (lamp_tst) begin
          dirty = 1'b1;
        end
      end
    end
  end

  function automatic bit higher_nonzero(input logic [15:0] v, input int k);
    for (int j = k + 1; j < N; j++) begin
      if (v[4*j +: 4] != 4'd0) return 1'b1;
    end
    return 1'b0;
  endfunction

  // Every-cycle comparison against the timeline model.
  always @(negedge clk) begin
    logic [3:0] e_an;
    logic [3:0] e_dcba;
    bit         e_bi;
    bit         e_rbi;
    bit         e_fr;
    int         ft;
    int         w;
    int         k;
    if (chk_on) begin
      e_an   = 4'hF;
      e_dcba = 4'd0;
      e_bi   = 1'b0;
      e_rbi  = 1'b1;
      e_fr   = 1'b0;
      if (run_t >= 0) begin
        ft     = run_t % FRAME;
        w      = ft % SLOT;
        k      = N - 1 - ft / SLOT;
        e_dcba = snap[4*k +: 4];
        if (w >= B) begin
          e_an[k] = 1'b0;
          e_bi    = 1'b1;
          e_fr    = (k == N - 1) && (w == B);
        end
        if (LZB && lt_exp) begin
          if (k == N - 1)  e_rbi = 1'b0;
          else if (k == 0) e_rbi = 1'b1;
          else             e_rbi = higher_nonzero(snap, k);
        end
      end
      check("model anode_n", 32'(anode_n), 32'(e_an));
      check("model bi_n", 32'(bi_n), 32'(e_bi));
      check("model dcba", 32'(dcba), 32'(e_dcba));
      check("model frame", 32'(frame), 32'(e_fr));
      check("model lt_n", 32'(lt_n), 32'(lt_exp));
      if (!(LZB && dirty && lt_exp)) check("model rbi_n", 32'(rbi_n), 32'(e_rbi));
    end
  end

  task automatic wait_anode(input logic [3:0] want, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      if (anode_n === want) ok = 1'b1;
    end
    if (!ok) check("wait anode timeout", 32'(anode_n), 32'(want));
  endtask

  task automatic show_digit(input int k, input logic [3:0] code, input bit rbi_e,
                            input bit lit_e);
    bit         ok;
    logic [3:0] want;
    bit         lit;
    want = ~(4'b0001 << k);
    wait_anode(want, ok);
    if (ok) begin
      lit = !lt_n || rbi_n || (dcba != 4'd0);
      check("digit dcba", 32'(dcba), 32'(code));
      check("digit rbi_n", 32'(rbi_n), 32'(rbi_e));
      check("digit lit", 32'(lit), 32'(lit_e));
    end
  endtask

  task automatic start_scan(input logic [15:0] v);
    @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    bcd_in = v;
    en     = 1'b1;
  endtask

  typedef struct {
    logic [15:0] bcd;
    logic [3:0]  rbi_lzb;  // bit k = expected rbi_n on digit k with blanking enabled
    logic [3:0]  lit_lzb;  // bit k = digit k visibly lit with blanking enabled
  } vec_t;

  vec_t tbl[6];

  initial begin
    bit         ok;
    logic [15:0] v;
    int         cnt;

    tbl[0] = '{16'h1234, 4'b0111, 4'b1111};
    tbl[1] = '{16'h0050, 4'b0001, 4'b0011};
    tbl[2] = '{16'h0000, 4'b0001, 4'b0001};
    tbl[3] = '{16'h1000, 4'b0111, 4'b1111};
    tbl[4] = '{16'h0A00, 4'b0011, 4'b0111};
    tbl[5] = '{16'h0009, 4'b0001, 4'b0001};

    rst_n    = 1'b0;
    en       = 1'b0;
    lamp_tst = 1'b0;
    bcd_in   = '0;
    repeat (2) @(negedge clk);
    check("reset anode_n", 32'(anode_n), 32'hF);
    check("reset bi_n", 32'(bi_n), 32'h0);
    check("reset lt_n", 32'(lt_n), 32'h1);
    check("reset rbi_n", 32'(rbi_n), 32'h1);
    #2 rst_n = 1'b1;
    chk_on = 1'b1;

    // Table: per-digit code, ripple-blank input and visibility.
    for (int i = 0; i < 6; i++) begin
      start_scan(tbl[i].bcd);
      v = tbl[i].bcd;
      for (int k = N - 1; k >= 0; k--) begin
        show_digit(k, v[4*k +: 4], LZB ? tbl[i].rbi_lzb[k] : 1'b1,
                   LZB ? tbl[i].lit_lzb[k] : 1'b1);
      end
    end

    // Asynchronous reset mid-SHOW, then restart timing.
    start_scan(16'h1234);
    wait_anode(4'b1011, ok);
    #2 rst_n = 1'b0;
    #1;
    check("async rst anode_n", 32'(anode_n), 32'hF);
    check("async rst bi_n", 32'(bi_n), 32'h0);
    check("async rst dcba", 32'(dcba), 32'h0);
    check("async rst frame", 32'(frame), 32'h0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("restart blank1", 32'(anode_n), 32'hF);
    @(negedge clk);
    check("restart blank2", 32'(anode_n), 32'hF);
    @(negedge clk);
    check("restart show", 32'(anode_n), 32'h7);
    check("restart dcba", 32'(dcba), 32'h1);

    // Frame pulse period.
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (frame === 1'b1) ok = 1'b1;
    end
    if (!ok) check("frame timeout", 32'(frame), 32'h1);
    cnt = 0;
    ok  = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      cnt++;
      if (frame === 1'b1) ok = 1'b1;
    end
    check("frame period", 32'(cnt), 32'(FRAME));

    // Mid-frame input change takes effect at the next frame only.
    start_scan(16'h1234);
    wait_anode(4'b1011, ok);
    bcd_in = 16'h5678;
    show_digit(1, 4'd3, 1'b1, 1'b1);
    show_digit(0, 4'd4, 1'b1, 1'b1);
    show_digit(3, 4'd5, !LZB, 1'b1);
    show_digit(2, 4'd6, 1'b1, 1'b1);
    show_digit(1, 4'd7, 1'b1, 1'b1);
    show_digit(0, 4'd8, 1'b1, 1'b1);

    // Lamp test mid-frame, then disable.
    start_scan(16'h0050);
    wait_anode(4'b1101, ok);
    lamp_tst = 1'b1;
    @(negedge clk);
    check("lamp lt_n", 32'(lt_n), 32'h0);
    check("lamp rbi_n", 32'(rbi_n), 32'h1);
    check("lamp anode_n", 32'(anode_n), 32'hD);
    wait_anode(4'b1110, ok);
    check("lamp scan rbi_n", 32'(rbi_n), 32'h1);
    en = 1'b0;
    @(negedge clk);
    check("disable anode_n", 32'(anode_n), 32'hF);
    check("disable bi_n", 32'(bi_n), 32'h0);
    lamp_tst = 1'b0;

    // Randomized traffic against the timeline model.
    en = 1'b1;
    for (int it = 0; it < 60; it++) begin
      for (int k = 0; k < N; k++) begin
        v[4*k +: 4] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      end
      bcd_in = v;
      if ($urandom_range(0, 7) == 0) en = 1'b0;
      else en = 1'b1;
      lamp_tst = ($urandom_range(0, 9) == 0);
      repeat ($urandom_range(1, 3)) @(negedge clk);
      lamp_tst = 1'b0;
      en       = 1'b1;
      repeat ($urandom_range(1, 40)) @(negedge clk);
    end

    @(negedge clk);
    chk_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
